record_jtag_tdo: RTL and testbench
==================================

Name: record_jtag_tdo

Overview:
- Capture-side counterpart of the JTAG vector player: samples TDO once per JTAG step, using the same request/ready four-phase handshake the player uses for TMS/TDI.
- Packs 8 TDO bits per byte, LSB first, and writes the bytes to a 4096x8 capture RAM through a single write port.
- Host logic arms a capture with a bit length and reads the RAM after done.

Parameters:
- ADDR_W, 12, byte address width of the capture RAM; capacity is 2^ADDR_W*8 bits.
- LEN_W, 16, width of record_length and bit_count.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that arms a new capture
- abort  in  1  one-cycle pulse that stops a capture immediately
- record_length  in  LEN_W  number of TDO bits to capture; sampled on start
- get_tdo  in  1  capture request from the JTAG driver; asynchronous level
- tdo  in  1  TDO pin; asynchronous
- tdo_ack  out  1  capture acknowledge (four-phase handshake)
- tdo_mem_addr  out  ADDR_W  RAM byte address
- tdo_mem_we  out  1  RAM write strobe, one cycle per byte
- tdo_mem_wr_data  out  8  RAM write data
- bit_count  out  LEN_W  number of bits captured so far
- busy  out  1  high in ARMED or FLUSH
- done  out  1  sticky completion flag; cleared by start
- overflow  out  1  sticky; set when record_length exceeds RAM capacity

Behaviour:
- Reset values: every output 0; shift register 0; state IDLE.
- Input synchronisation: get_tdo and tdo each pass through a 2-FF synchroniser, clocked together so that req_s and tdo_s stay aligned.
- State IDLE:
  - On start: latch len = min(record_length, 2^(ADDR_W+3)).
  - Set overflow if record_length exceeded capacity.
  - Clear bit_count, done and the shift register.
  - len==0: go to DONE.
  - Otherwise: go to ARMED.
- State ARMED, capture:
  - When req_s && !tdo_ack: shift tdo_s into bit position bit_count[2:0], set tdo_ack=1, increment bit_count.
  - tdo_ack falls on the first cycle with !req_s.
  - Exactly one bit is captured per request high phase.
- Byte write:
  - A capture that fills bit 7 asserts tdo_mem_we on the next cycle.
  - In that cycle: wr_data = the full byte; addr = bit_count[ADDR_W+2:3] of the captured bit, i.e. (bit_count-1)>>3.
  - The shift register clears in the same cycle.
- Completion from ARMED:
  - When the captured bit makes bit_count==len:
    - Byte full: the write goes out normally, then done=1 and state goes to DONE.
    - Partial byte: go to FLUSH.
- State FLUSH: one cycle. Writes the partial byte with upper unused bits 0, then sets done=1 and goes to DONE.
- State DONE:
  - tdo_ack still completes its handshake; further requests are not captured and not acknowledged.
  - start re-arms the block (same as from IDLE).
- Pulse collisions:
  - start while ARMED: ignored.
  - abort in any state: go to IDLE, discard the partial byte, no write, done stays 0, tdo_ack driven 0.
  - abort and start in the same cycle: abort wins.
- Reset mid-capture: all state cleared asynchronously; no write is issued.
- Latency: tdo pin to tdo_ack rising = 3 clk after get_tdo rises (2 sync + 1).
- The driver must hold tdo stable from raising get_tdo until it sees tdo_ack.

Decomposition:
- Shared package jtag_pkg holds:
  - state encoding: IDLE, ARMED, FLUSH, DONE;
  - constant BITS_PER_BYTE=8;
  - capacity derivation from ADDR_W.
- One natural sub-module: sync_2ff (1-bit two-flop synchroniser), instantiated twice.

Test Plan:
- Full byte: start with len=8; TDO pattern 1,0,1,1,0,0,1,0 over 8 handshakes -> one write at addr 0 with data 0x4D; done=1; bit_count=8.
- Partial flush: len=11; all TDO bits 1 -> writes 0xFF at addr 0 and 0x07 at addr 1 (FLUSH); done=1.
- Handshake discipline: get_tdo held high 20 cycles -> exactly one capture, tdo_ack high until get_tdo falls, ack falls 3 cycles after get_tdo falls.
- Overflow: len=0xFFFF with ADDR_W=12 -> overflow=1; capture stops at 32768 bits; last write at addr 0xFFF; no address wrap.
- Abort: len=16, abort after 5 bits -> no tdo_mem_we; state IDLE; done=0; a following start with len=0 -> done=1 immediately with no writes.
- Reset: rst_n low after 12 bits captured -> all outputs 0 within the same cycle; no spurious we after release.

Source files
------------

// File: rtl/jtag_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtag_pkg : shared types and constants for the JTAG TDO capture path  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package jtag_pkg;

  localparam int unsigned BITS_PER_BYTE = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } cap_state_e;

  function automatic int unsigned capacity_bits(input int unsigned addr_w);
    return (32'd1 << addr_w) * BITS_PER_BYTE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_2ff : single-bit two-flop synchroniser                          |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/record_jtag_tdo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | record_jtag_tdo : samples TDO per JTAG step, packs bytes into a RAM  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module record_jtag_tdo
  import jtag_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  record_length,
  input  logic              get_tdo,
  input  logic              tdo,
  output logic              tdo_ack,
  output logic [ADDR_W-1:0] tdo_mem_addr,
  output logic              tdo_mem_we,
  output logic [7:0]        tdo_mem_wr_data,
  output logic [LEN_W-1:0]  bit_count,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int unsigned CAP_BITS = capacity_bits(ADDR_W);

  logic req_s;
  logic tdo_s;

  sync_2ff u_sync_req (.clk(clk), .rst_n(rst_n), .d(get_tdo), .q(req_s));
  sync_2ff u_sync_tdo (.clk(clk), .rst_n(rst_n), .d(tdo),     .q(tdo_s));

  cap_state_e        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  bit_count_q, bit_count_d;
  logic [7:0]        shift_q, shift_d;
  logic              ack_q, ack_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;

  logic [2:0]        bit_idx;
  logic [7:0]        shift_ins;
  logic              len_over;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    bit_count_d = bit_count_q;
    shift_d     = shift_q;
    ack_d       = ack_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    done_d      = done_q;
    overflow_d  = overflow_q;
    bit_idx     = bit_count_q[2:0];
    shift_ins   = shift_q | (8'(tdo_s) << bit_idx);
    len_over    = 32'(record_length) > CAP_BITS;

    // The acknowledge always completes its handshake, even after capture ends.
    if (!req_s) ack_d = 1'b0;

    if (abort) begin
      state_d = IDLE;
      shift_d = 8'h00;
      ack_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            len_d       = len_over ? LEN_W'(CAP_BITS) : record_length;
            overflow_d  = overflow_q | len_over;
            bit_count_d = '0;
            shift_d     = 8'h00;
            done_d      = (record_length == '0);
            state_d     = (record_length == '0) ? DONE : ARMED;
          end
        end
        ARMED: begin
          if (req_s && !ack_q) begin
            ack_d       = 1'b1;
            bit_count_d = bit_count_q + 1'b1;
            shift_d     = shift_ins;
            if (bit_idx == 3'd7) begin
              we_d      = 1'b1;
              addr_d    = bit_count_q[ADDR_W+2:3];
              wr_data_d = shift_ins;
              shift_d   = 8'h00;
            end
            if (bit_count_d == len_q) begin
              if (bit_idx == 3'd7) begin
                state_d = DONE;
                done_d  = 1'b1;
              end else begin
                state_d = FLUSH;
              end
            end
          end
        end
        FLUSH: begin
          // Unfilled upper bits are already zero in the shift register.
          we_d      = 1'b1;
          addr_d    = bit_count_q[ADDR_W+2:3];
          wr_data_d = shift_q;
          shift_d   = 8'h00;
          done_d    = 1'b1;
          state_d   = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      bit_count_q <= '0;
      shift_q     <= 8'h00;
      ack_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= 8'h00;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      bit_count_q <= bit_count_d;
      shift_q     <= shift_d;
      ack_q       <= ack_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  assign tdo_ack         = ack_q;
  assign tdo_mem_addr    = addr_q;
  assign tdo_mem_we      = we_q;
  assign tdo_mem_wr_data = wr_data_q;
  assign bit_count       = bit_count_q;
  assign busy            = (state_q == ARMED) || (state_q == FLUSH);
  assign done            = done_q;
  assign overflow        = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_record_jtag_tdo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_record_jtag_tdo : directed vector bench for record_jtag_tdo       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_record_jtag_tdo;

  // A 32-byte RAM keeps the capacity-limit run short.
  localparam int ADDR_W = 5;
  localparam int LEN_W  = 16;
  localparam int CAP    = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [LEN_W-1:0]  record_length = '0;
  logic              get_tdo = 1'b0;
  logic              tdo = 1'b0;
  logic              tdo_ack;
  logic [ADDR_W-1:0] tdo_mem_addr;
  logic              tdo_mem_we;
  logic [7:0]        tdo_mem_wr_data;
  logic [LEN_W-1:0]  bit_count;
  logic              busy;
  logic              done;
  logic              overflow;

  int total  = 0;
  int passed = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [7:0]        wr_data_q[$];

  always #5 clk = ~clk;

  record_jtag_tdo #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .record_length(record_length), .get_tdo(get_tdo), .tdo(tdo),
    .tdo_ack(tdo_ack), .tdo_mem_addr(tdo_mem_addr), .tdo_mem_we(tdo_mem_we),
    .tdo_mem_wr_data(tdo_mem_wr_data), .bit_count(bit_count), .busy(busy),
    .done(done), .overflow(overflow)
  );

  always @(negedge clk) begin
    if (rst_n && tdo_mem_we) begin
      wr_addr_q.push_back(tdo_mem_addr);
      wr_data_q.push_back(tdo_mem_wr_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic pulse_start(input logic [LEN_W-1:0] len);
    record_length = len;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic handshake(input logic b);
    int n;
    tdo = b;
    get_tdo = 1'b1;
    n = 0;
    while (!tdo_ack && n < 20) begin @(negedge clk); n++; end
    if (!tdo_ack) begin
      total++;
      $display("FAIL hs_ack_rise: tdo_ack=%0b, required 1 within 20 cycles", tdo_ack);
    end
    get_tdo = 1'b0;
    n = 0;
    while (tdo_ack && n < 20) begin @(negedge clk); n++; end
    if (tdo_ack) begin
      total++;
      $display("FAIL hs_ack_fall: tdo_ack=%0b, required 0 within 20 cycles", tdo_ack);
    end
  endtask

  typedef struct {
    logic [15:0] len;
    logic [15:0] bits;
    int          nwr;
    logic [7:0]  d0;
    logic [7:0]  d1;
  } vec_t;

  vec_t vecs[5];
  logic [7:0] exp_bytes[32];

  initial begin
    int n;
    int rise_at;
    logic ack_held;
    vecs[0] = '{len: 16'd8,  bits: 16'h004D, nwr: 1, d0: 8'h4D, d1: 8'h00};
    vecs[1] = '{len: 16'd11, bits: 16'h07FF, nwr: 2, d0: 8'hFF, d1: 8'h07};
    vecs[2] = '{len: 16'd3,  bits: 16'h0005, nwr: 1, d0: 8'h05, d1: 8'h00};
    vecs[3] = '{len: 16'd16, bits: 16'hA53C, nwr: 2, d0: 8'h3C, d1: 8'hA5};
    vecs[4] = '{len: 16'd1,  bits: 16'h0000, nwr: 1, d0: 8'h00, d1: 8'h00};

    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {31'(0), tdo_ack} | {27'(0), tdo_mem_addr} | {31'(0), tdo_mem_we} |
        {24'(0), tdo_mem_wr_data} | {16'(0), bit_count} | {29'(0), busy, done, overflow}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven captures
    foreach (vecs[v]) begin
      wr_addr_q.delete();
      wr_data_q.delete();
      pulse_start(vecs[v].len);
      chk($sformatf("v%0d_busy_armed", v), busy, 1);
      for (int i = 0; i < int'(vecs[v].len); i++) handshake(vecs[v].bits[i]);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_nwr", v), wr_addr_q.size(), vecs[v].nwr);
      if (wr_addr_q.size() >= 1) begin
        chk($sformatf("v%0d_addr0", v), wr_addr_q[0], 0);
        chk($sformatf("v%0d_data0", v), wr_data_q[0], vecs[v].d0);
      end
      if (vecs[v].nwr > 1 && wr_addr_q.size() >= 2) begin
        chk($sformatf("v%0d_addr1", v), wr_addr_q[1], 1);
        chk($sformatf("v%0d_data1", v), wr_data_q[1], vecs[v].d1);
      end
      chk($sformatf("v%0d_done", v), done, 1);
      chk($sformatf("v%0d_bit_count", v), bit_count, vecs[v].len);
      chk($sformatf("v%0d_busy_idle", v), busy, 0);
      chk($sformatf("v%0d_overflow", v), overflow, 0);
    end

    // Held request: one capture, ack timing 3 cycles after each edge
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start(16'd2);
    chk("hold_done_cleared", done, 0);
    tdo = 1'b1;
    get_tdo = 1'b1;
    rise_at = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (tdo_ack && rise_at < 0) rise_at = c;
    end
    chk("hold_ack_rise_cycle", rise_at, 3);
    chk("hold_one_capture", bit_count, 1);
    get_tdo = 1'b0;
    n = 0;
    ack_held = 1'b1;
    for (int c = 1; c <= 2; c++) begin @(negedge clk); ack_held &= tdo_ack; end
    chk("hold_ack_until_fall", ack_held, 1);
    @(negedge clk);
    chk("hold_ack_fall_3", tdo_ack, 0);
    handshake(1'b0);
    repeat (3) @(negedge clk);
    chk("hold_nwr", wr_addr_q.size(), 1);
    if (wr_data_q.size() >= 1) chk("hold_flush_data", wr_data_q[0], 8'h01);
    chk("hold_done", done, 1);

    // Requests in DONE are neither captured nor acknowledged
    get_tdo = 1'b1;
    ack_held = 1'b0;
    repeat (8) begin @(negedge clk); ack_held |= tdo_ack; end
    get_tdo = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_no_ack", ack_held, 0);
    chk("done_no_capture", bit_count, 2);

    // Abort mid-capture, start ignored while ARMED
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start(16'd16);
    for (int i = 0; i < 5; i++) handshake(1'b1);
    pulse_start(16'd4);
    chk("armed_start_ignored_cnt", bit_count, 5);
    chk("armed_start_ignored_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_no_we", wr_addr_q.size(), 0);
    pulse_start(16'd0);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("len0_no_we", wr_addr_q.size(), 0);

    // Abort and start together: abort wins
    abort = 1'b1;
    pulse_start(16'd5);
    abort = 1'b0;
    @(negedge clk);
    chk("abort_beats_start", busy, 0);

    // Overflow: capture stops at RAM capacity
    for (int k = 0; k < 32; k++) begin
      exp_bytes[k] = 8'h00;
      for (int j = 0; j < 8; j++) exp_bytes[k][j] = ((8 * k + j) % 3 == 0);
    end
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start(16'hFFFF);
    chk("ovf_flag", overflow, 1);
    chk("ovf_busy", busy, 1);
    for (int i = 0; i < CAP; i++) handshake(((i % 3) == 0) ? 1'b1 : 1'b0);
    repeat (3) @(negedge clk);
    chk("ovf_done", done, 1);
    chk("ovf_bit_count", bit_count, CAP);
    chk("ovf_nwr", wr_addr_q.size(), 32);
    n = 0;
    for (int k = 0; k < 32 && k < wr_addr_q.size(); k++)
      if (wr_addr_q[k] !== 5'(k) || wr_data_q[k] !== exp_bytes[k]) n++;
    chk("ovf_write_stream_errs", n, 0);
    if (wr_addr_q.size() > 0) chk("ovf_last_addr", wr_addr_q[wr_addr_q.size() - 1], 5'h1F);
    get_tdo = 1'b1;
    repeat (8) @(negedge clk);
    get_tdo = 1'b0;
    repeat (4) @(negedge clk);
    chk("ovf_no_wrap", wr_addr_q.size(), 32);

    // Reset mid-capture
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start(16'd40);
    for (int i = 0; i < 12; i++) handshake(1'b1);
    chk("rst_pre_nwr", wr_addr_q.size(), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs",
        {31'(0), tdo_ack} | {27'(0), tdo_mem_addr} | {31'(0), tdo_mem_we} |
        {24'(0), tdo_mem_wr_data} | {16'(0), bit_count} | {29'(0), busy, done, overflow}, 0);
    @(negedge clk);
    wr_addr_q.delete();
    wr_data_q.delete();
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_no_spurious_we", wr_addr_q.size(), 0);
    chk("rst_busy", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
